// File: rtl/mips_control_fsm_if.sv
// Memory-side handshake between the MIPS control unit and the data/instruction memory port.
// Carries the address low bits and waitrequest in, and the access strobes and byte lanes out.
interface mips_control_fsm_if;
    logic [1:0] addr_lo;
    logic       waitrequest;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic [3:0] byteenable;

    modport master (
        input  addr_lo,
        input  waitrequest,
        output IorD,
        output MemRead,
        output MemWrite,
        output byteenable
    );

    modport slave (
        output addr_lo,
        output waitrequest,
        input  IorD,
        input  MemRead,
        input  MemWrite,
        input  byteenable
    );
endinterface

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: state sequencer plus per-state datapath control decoder.
// Define MIPS_CTRL_MULDIV_EN to build the multi-cycle MULT/DIV hold and the HI/LO write strobe.
module mips_control_fsm #(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func_code,
    input  logic               pc_is_zero,
    mips_control_fsm_if.master mem,
    output logic [2:0]         state,
    output logic               active,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic               unsign,
    output logic               fixed_shift,
    output logic               hilo_write,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [3:0]         ALUctl
);

    localparam int unsigned ALU_W = 4;

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_XOR = ALU_W'(10);
    localparam logic [ALU_W-1:0] ALU_SLL = ALU_W'(11);
    localparam logic [ALU_W-1:0] ALU_SRL = ALU_W'(12);
    localparam logic [ALU_W-1:0] ALU_SRA = ALU_W'(13);

`ifdef MIPS_CTRL_MULDIV_EN
    localparam int unsigned CNT_W = 4;
    localparam logic [ALU_W-1:0] ALU_MUL  = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_DIV  = ALU_W'(8);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
`endif

    if (MULDIV_CYCLES < 1 || MULDIV_CYCLES > 15) begin : g_bad_muldiv_cycles
        $error("mips_control_fsm: MULDIV_CYCLES must be in 1..15");
    end

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_DECODE     = 3'd1,
        S_EXECUTE    = 3'd2,
        S_MEM_ACCESS = 3'd3,
        S_WRITE_BACK = 3'd4,
        S_HALT       = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_JR,
        CLS_MULDIV
    } cls_e;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } size_e;

    state_e           state_q, state_d;
    logic             active_q, active_d;
`ifdef MIPS_CTRL_MULDIV_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    cls_e             cls;
    size_e            dec_size;
    logic [ALU_W-1:0] dec_aluctl;
    logic             dec_unsign;
    logic             dec_fixed_shift;
    logic [3:0]       be_c;

    // Instruction class and ALU operation straight from the IR fields.
    always_comb begin
        cls             = CLS_NONE;
        dec_size        = SZ_WORD;
        dec_aluctl      = ALU_ADD;
        dec_unsign      = 1'b0;
        dec_fixed_shift = 1'b0;
        if (opcode == 6'h00) begin
            cls = CLS_ALU_R;
            case (func_code)
                6'h00: begin dec_aluctl = ALU_SLL; dec_fixed_shift = 1'b1; end
                6'h02: begin dec_aluctl = ALU_SRL; dec_fixed_shift = 1'b1; end
                6'h03: begin dec_aluctl = ALU_SRA; dec_fixed_shift = 1'b1; end
                6'h04: dec_aluctl = ALU_SLL;
                6'h06: dec_aluctl = ALU_SRL;
                6'h07: dec_aluctl = ALU_SRA;
                6'h08: cls = CLS_JR;
                6'h21: dec_aluctl = ALU_ADD;
                6'h23: begin dec_aluctl = ALU_SUB; dec_unsign = 1'b1; end
                6'h24: dec_aluctl = ALU_AND;
                6'h25: dec_aluctl = ALU_OR;
                6'h26: dec_aluctl = ALU_XOR;
                6'h2A: dec_aluctl = ALU_SLT;
                6'h2B: begin dec_aluctl = ALU_SLT; dec_unsign = 1'b1; end
`ifdef MIPS_CTRL_MULDIV_EN
                6'h18: begin cls = CLS_MULDIV; dec_aluctl = ALU_MUL; end
                6'h19: begin cls = CLS_MULDIV; dec_aluctl = ALU_MUL; dec_unsign = 1'b1; end
                6'h1A: begin cls = CLS_MULDIV; dec_aluctl = ALU_DIV; end
                6'h1B: begin cls = CLS_MULDIV; dec_aluctl = ALU_DIV; dec_unsign = 1'b1; end
`endif
                default: cls = CLS_NONE;
            endcase
        end else begin
            case (opcode)
                6'h09: begin cls = CLS_ALU_I; dec_aluctl = ALU_ADD; end
                6'h0A: begin cls = CLS_ALU_I; dec_aluctl = ALU_SLT; end
                6'h0B: begin cls = CLS_ALU_I; dec_aluctl = ALU_SLT; dec_unsign = 1'b1; end
                6'h0C: begin cls = CLS_ALU_I; dec_aluctl = ALU_AND; end
                6'h0D: begin cls = CLS_ALU_I; dec_aluctl = ALU_OR; end
                6'h0E: begin cls = CLS_ALU_I; dec_aluctl = ALU_XOR; end
                6'h20: begin cls = CLS_LOAD;  dec_size = SZ_BYTE; end
                6'h24: begin cls = CLS_LOAD;  dec_size = SZ_BYTE; end
                6'h21: begin cls = CLS_LOAD;  dec_size = SZ_HALF; end
                6'h25: begin cls = CLS_LOAD;  dec_size = SZ_HALF; end
                6'h23: begin cls = CLS_LOAD;  dec_size = SZ_WORD; end
                6'h28: begin cls = CLS_STORE; dec_size = SZ_BYTE; end
                6'h29: begin cls = CLS_STORE; dec_size = SZ_HALF; end
                6'h2B: begin cls = CLS_STORE; dec_size = SZ_WORD; end
                default: cls = CLS_NONE;
            endcase
        end
    end

    // Half-word lanes follow addr_lo[1] only; misaligned bit 0 is ignored.
    always_comb begin
        case (dec_size)
            SZ_BYTE: be_c = 4'b0001 << mem.addr_lo;
            SZ_HALF: be_c = mem.addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be_c = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            active_q <= 1'b0;
`ifdef MIPS_CTRL_MULDIV_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
`ifdef MIPS_CTRL_MULDIV_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign active_d = (state_d != S_HALT);

    // Next state and control outputs; reset gating at the end forces strobes low at once.
    always_comb begin
        state_d        = state_q;
        RegDst         = 1'b0;
        RegWrite       = 1'b0;
        ALUSrcA        = 1'b1;
        PCWrite        = 1'b0;
        PCWriteCond    = 1'b0;
        MemtoReg       = 1'b0;
        IRWrite        = 1'b0;
        unsign         = 1'b0;
        fixed_shift    = 1'b0;
        hilo_write     = 1'b0;
        ALUSrcB        = 2'b00;
        PCSource       = 2'b00;
        ALUctl         = ALU_ADD;
        mem.IorD       = 1'b0;
        mem.MemRead    = 1'b0;
        mem.MemWrite   = 1'b0;
        mem.byteenable = 4'b1111;
`ifdef MIPS_CTRL_MULDIV_EN
        cnt_d          = cnt_q;
`endif

        case (state_q)
            S_FETCH: begin
                if (pc_is_zero) begin
                    state_d = S_HALT;
                end else begin
                    mem.MemRead = 1'b1;
                    ALUSrcA     = 1'b0;
                    ALUSrcB     = 2'b01;
                    ALUctl      = ALU_ADD;
                    if (!mem.waitrequest) begin
                        PCWrite  = 1'b1;
                        PCSource = 2'b00;
                        state_d  = S_DECODE;
                    end
                end
            end

            S_DECODE: begin
                IRWrite = 1'b1;
                ALUSrcA = 1'b0;
                ALUSrcB = 2'b10;
                ALUctl  = ALU_ADD;
                state_d = S_EXECUTE;
`ifdef MIPS_CTRL_MULDIV_EN
                cnt_d   = CNT_LOAD;
`endif
            end

            S_EXECUTE: begin
                state_d = S_FETCH;
                case (cls)
                    CLS_ALU_R: begin
                        ALUSrcB     = 2'b00;
                        ALUctl      = dec_aluctl;
                        unsign      = dec_unsign;
                        fixed_shift = dec_fixed_shift;
                        state_d     = S_WRITE_BACK;
                    end
                    CLS_ALU_I: begin
                        ALUSrcB = 2'b10;
                        ALUctl  = dec_aluctl;
                        unsign  = dec_unsign;
                        state_d = S_WRITE_BACK;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        ALUSrcB = 2'b10;
                        ALUctl  = ALU_ADD;
                        state_d = S_MEM_ACCESS;
                    end
                    CLS_JR: begin
                        ALUSrcB  = 2'b00;
                        ALUctl   = ALU_ADD;
                        PCWrite  = 1'b1;
                        PCSource = 2'b00;
                    end
`ifdef MIPS_CTRL_MULDIV_EN
                    CLS_MULDIV: begin
                        ALUSrcB = 2'b00;
                        ALUctl  = dec_aluctl;
                        unsign  = dec_unsign;
                        if (cnt_q == '0) begin
                            hilo_write = 1'b1;
                        end else begin
                            cnt_d   = cnt_q - CNT_W'(1);
                            state_d = S_EXECUTE;
                        end
                    end
`endif
                    default: ;
                endcase
            end

            S_MEM_ACCESS: begin
                mem.IorD       = 1'b1;
                mem.byteenable = be_c;
                if (cls == CLS_LOAD) begin
                    mem.MemRead = 1'b1;
                    if (!mem.waitrequest) state_d = S_WRITE_BACK;
                end else begin
                    mem.MemWrite = 1'b1;
                    if (!mem.waitrequest) state_d = S_FETCH;
                end
            end

            S_WRITE_BACK: begin
                RegWrite = 1'b1;
                RegDst   = (cls == CLS_ALU_R);
                MemtoReg = (cls == CLS_LOAD);
                state_d  = S_FETCH;
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_FETCH;
        endcase

        if (!reset_n) begin
            RegDst         = 1'b0;
            RegWrite       = 1'b0;
            ALUSrcA        = 1'b1;
            PCWrite        = 1'b0;
            PCWriteCond    = 1'b0;
            MemtoReg       = 1'b0;
            IRWrite        = 1'b0;
            unsign         = 1'b0;
            fixed_shift    = 1'b0;
            hilo_write     = 1'b0;
            ALUSrcB        = 2'b00;
            PCSource       = 2'b00;
            ALUctl         = ALU_ADD;
            mem.IorD       = 1'b0;
            mem.MemRead    = 1'b0;
            mem.MemWrite   = 1'b0;
            mem.byteenable = 4'b0000;
        end
    end

    assign state  = state_q;
    assign active = active_q;

endmodule
